// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary register with a 2-entry skid buffer.
// The main entry (M) drives the memory stage. The skid entry (S) catches the
// one beat that EX can still push after MEM stalls. in_ready is a flop, so
// there is no combinational path from out_ready back into EX.
// The branch-taken decision is resolved once, when the beat is captured.
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [3:0]        in_ctrl,
    input  logic              in_branch,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic [3:0]        out_ctrl,
    output logic              out_branch_taken,
    output logic [1:0]        occupancy
);

    // Packed payload: {alu_result, store_data, rd, ctrl, branch_taken}
    localparam int PW = 2 * DATA_W + REG_W + 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   m_data_r;
    logic [PW-1:0]   s_data_r;
    logic [PW-1:0]   in_data_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [1:0]      occupancy_r;
    logic            accept_s;
    logic            drain_s;
    logic            load_m_in_s;
    logic            load_s_in_s;
    logic            move_s_m_s;

    assign accept_s  = in_valid & in_ready_r;
    assign drain_s   = out_valid_r & out_ready;
    assign in_data_s = {in_alu_result, in_store_data, in_rd, in_ctrl, in_branch & in_zero};

    // Next-state logic; flush overrides everything and empties the buffer
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) state_next_s = ST_ONE;
                    else          state_next_s = ST_EMPTY;
                end
                ST_ONE: begin
                    if (accept_s && !drain_s)      state_next_s = ST_FULL;
                    else if (!accept_s && drain_s) state_next_s = ST_EMPTY;
                    else                           state_next_s = ST_ONE;
                end
                ST_FULL: begin
                    if (drain_s) state_next_s = ST_ONE;
                    else         state_next_s = ST_FULL;
                end
                default: state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Datapath steering: which payload register loads from where this cycle
    always_comb begin
        load_m_in_s = 1'b0;
        load_s_in_s = 1'b0;
        move_s_m_s  = 1'b0;
        if (!flush) begin
            case (state_r)
                ST_EMPTY: load_m_in_s = accept_s;
                ST_ONE: begin
                    load_m_in_s = accept_s & drain_s;
                    load_s_in_s = accept_s & ~drain_s;
                end
                ST_FULL:  move_s_m_s  = drain_s;
                default: begin
                    load_m_in_s = 1'b0;
                    load_s_in_s = 1'b0;
                    move_s_m_s  = 1'b0;
                end
            endcase
        end else begin
            load_m_in_s = 1'b0;
            load_s_in_s = 1'b0;
            move_s_m_s  = 1'b0;
        end
    end

    // State register plus flopped handshake/occupancy outputs derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            out_valid_r <= (state_next_s != ST_EMPTY);
            case (state_next_s)
                ST_EMPTY: occupancy_r <= 2'd0;
                ST_ONE:   occupancy_r <= 2'd1;
                ST_FULL:  occupancy_r <= 2'd2;
                default:  occupancy_r <= 2'd0;
            endcase
        end
    end

    // Payload registers: change only when a load or skid-to-main move happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r <= {PW{1'b0}};
            s_data_r <= {PW{1'b0}};
        end else begin
            if (load_m_in_s)     m_data_r <= in_data_s;
            else if (move_s_m_s) m_data_r <= s_data_r;
            else                 m_data_r <= m_data_r;
            if (load_s_in_s)     s_data_r <= in_data_s;
            else                 s_data_r <= s_data_r;
        end
    end

    assign in_ready         = in_ready_r;
    assign out_valid        = out_valid_r;
    assign occupancy        = occupancy_r;
    assign out_alu_result   = m_data_r[PW-1 -: DATA_W];
    assign out_store_data   = m_data_r[PW-1-DATA_W -: DATA_W];
    assign out_rd           = m_data_r[REG_W+4 -: REG_W];
    assign out_ctrl         = m_data_r[4:1];
    assign out_branch_taken = m_data_r[0];

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg. The reference model is a FIFO of
// expected beats limited to two entries; a monitor compares every drained beat
// and the handshake/occupancy view against it.
module tb_ex_mem_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic        in_zero;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic [3:0]  in_ctrl;
    logic        in_branch;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_ctrl;
    logic        out_branch_taken;
    logic [1:0]  occupancy;

    ex_mem_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_zero(in_zero),
        .in_store_data(in_store_data), .in_rd(in_rd),
        .in_ctrl(in_ctrl), .in_branch(in_branch), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_ctrl(out_ctrl),
        .out_branch_taken(out_branch_taken), .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        bt;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    logic pend_v;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT view with the model just before each rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("occupancy", 64'(occupancy), 64'(q.size()));
            check("in_ready",  64'(in_ready),  64'(q.size() < 2));
            if (out_valid && out_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("alu_result",   64'(out_alu_result),   64'(e.alu));
                check("store_data",   64'(out_store_data),   64'(e.sd));
                check("rd",           64'(out_rd),           64'(e.rd));
                check("ctrl",         64'(out_ctrl),         64'(e.ctrl));
                check("branch_taken", 64'(out_branch_taken), 64'(e.bt));
            end
            if (flush) q.delete();
        end
    end

    // One clock of stimulus; records whether the beat will be accepted at the next edge
    task automatic cyc(input logic v, input logic [31:0] alu, input logic z,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctrl,
                       input logic br, input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        if (pend_v) q.push_back(pend);
        pend_v        = 1'b0;
        in_valid      = v;
        in_alu_result = alu;
        in_zero       = z;
        in_store_data = sd;
        in_rd         = rd;
        in_ctrl       = ctrl;
        in_branch     = br;
        flush         = fl;
        out_ready     = ordy;
        @(negedge clk);
        pend.alu  = alu;
        pend.sd   = sd;
        pend.rd   = rd;
        pend.ctrl = ctrl;
        pend.bt   = br & z;
        pend_v    = v & in_ready & ~fl;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0, ordy);
    endtask

    // Present a beat until accepted, bounded
    task automatic send(input logic [31:0] alu, input logic ordy);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, alu, 1'b0, ~alu, alu[4:0], alu[3:0], 1'b0, 1'b0, ordy);
            if (pend_v) return;
        end
        check("send_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        checks = 0; failures = 0; pend_v = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_alu_result = 32'h0; in_zero = 1'b0;
        in_store_data = 32'h0; in_rd = 5'd0; in_ctrl = 4'h0; in_branch = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_alu",       64'(out_alu_result), 64'd0);
        check("rst_bt",        64'(out_branch_taken), 64'd0);
        #10 rst_n = 1'b1;

        // Single beat
        cyc(1'b1, 32'h10, 1'b0, 32'h0, 5'd5, 4'b1000, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("single_alu", 64'(out_alu_result), 64'h10);
        check("single_rd",  64'(out_rd), 64'd5);
        idle(1'b1);

        // Branch taken / not taken
        cyc(1'b1, 32'h0, 1'b1, 32'h0, 5'd1, 4'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd2, 4'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: A, B fill the buffer, C waits upstream
        cyc(1'b1, 32'h1, 1'b0, 32'h11, 5'd1, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2, 1'b0, 32'h22, 5'd2, 4'h2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3, 1'b0, 32'h33, 5'd3, 4'h3, 1'b0, 1'b0, 1'b0);
        check("bp_occupancy", 64'(occupancy), 64'd2);
        check("bp_in_ready",  64'(in_ready),  64'd0);
        check("bp_head",      64'(out_alu_result), 64'h1);
        send(32'h3, 1'b1);
        repeat (3) idle(1'b1);

        // Full throughput
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b1);
        repeat (2) idle(1'b1);

        // Flush while full, then a lone beat
        send(32'h5A, 1'b0);
        send(32'h5B, 1'b0);
        idle(1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        send(32'hAB, 1'b1);
        repeat (2) idle(1'b1);

        // Async reset mid-operation
        send(32'hC1, 1'b0);
        send(32'hC2, 1'b0);
        idle(1'b0);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_occupancy", 64'(occupancy), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        q.delete();
        pend_v = 1'b0;
        #1 rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $urandom, 1'($urandom),
                $urandom, 5'($urandom), 4'($urandom), 1'($urandom),
                ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end
        repeat (6) idle(1'b1);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
